// File: rtl/pc_sequencer.sv
// Fetch/PC controller: owns the architectural PC, drives the next-PC mux select,
// sequences the fetch handshake and handles EBREAK halt, misaligned targets and fetch timeouts.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        fetch_req,
  input  logic        fetch_ack,
  output logic        instr_valid,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic        ebreak,
  input  logic        resume,
  input  logic [31:0] pc_next,
  output logic [1:0]  pc_src,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT,
    FAULT
  } state_t;

  localparam logic [1:0] SRC_PLUS4  = 2'b00;
  localparam logic [1:0] SRC_TARGET = 2'b01;
  localparam logic [1:0] SRC_ALU    = 2'b10;
  localparam logic [1:0] SRC_BREAK  = 2'b11;

  // The counter value seen in the last permitted FETCH cycle; its increment
  // would reach TIMEOUT_CYCLES-1, so that cycle faults unless ack arrives.
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 2);

  state_t     state;
  logic [7:0] tcnt;
  logic       misaligned;

  assign pc_plus4    = pc + 32'd4;
  assign fetch_req   = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign misaligned  = (pc_next[1:0] != 2'b00);

  always_comb begin
    pc_src = SRC_BREAK;
    if (state == EXEC) begin
      if (ebreak)                     pc_src = SRC_BREAK;
      else if (jalr)                  pc_src = SRC_ALU;
      else if (jal)                   pc_src = SRC_TARGET;
      else if (branch && branch_taken) pc_src = SRC_TARGET;
      else                            pc_src = SRC_PLUS4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_VECTOR;
      instret <= 32'd0;
      tcnt    <= 8'd0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= 8'd0;
          if (run) state <= FETCH;
        end
        FETCH: begin
          if (fetch_ack) begin
            state <= EXEC;
            tcnt  <= 8'd0;
          end else if (tcnt == TCNT_LAST) begin
            state <= FAULT;
            fault <= 1'b1;
            tcnt  <= 8'd0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        EXEC: begin
          if (ebreak) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (misaligned) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            pc      <= pc_next;
            instret <= instret + 32'd1;
            state   <= FETCH;
          end
        end
        HALT: begin
          // Resuming steps over the EBREAK and counts it as retired.
          if (resume) begin
            pc      <= pc_plus4;
            instret <= instret + 32'd1;
            halted  <= 1'b0;
            state   <= FETCH;
          end
        end
        FAULT: begin
          fault <= 1'b1;
        end
        default: begin
          state  <= FAULT;
          fault  <= 1'b1;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Single-cycle core fetch/PC controller that owns the architectural PC register.
- Drives the select input of the next-PC multiplexer and receives the mux result back as pc_next.
- Sequences instruction fetch with a ready/ack handshake, and handles EBREAK halt/resume, misaligned-target faults and fetch timeouts.
- Keeps a retired-instruction counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum cycles FETCH waits for fetch_ack before faulting (range 2..255).

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- run  input  1  start execution; sampled only in IDLE
- fetch_req  output  1  instruction fetch request, address = pc
- fetch_ack  input  1  fetch data valid this cycle
- instr_valid  output  1  high in EXEC: decode inputs are valid
- branch  input  1  decoded conditional branch
- branch_taken  input  1  branch comparison result
- jal  input  1  decoded JAL
- jalr  input  1  decoded JALR
- ebreak  input  1  decoded EBREAK
- resume  input  1  leave HALT
- pc_next  input  32  next-PC mux output
- pc_src  output  2  mux select: PLUS4=2'b00, TARGET=2'b01, ALU=2'b10, BREAK=2'b11
- pc  output  32  current PC; also the mux pc_prev operand
- pc_plus4  output  32  pc + 4, modulo 2^32
- halted  output  1  high in HALT
- fault  output  1  high in FAULT
- instret  output  32  retired-instruction count

Behaviour:
- States: IDLE, FETCH, EXEC, HALT, FAULT.
- Reset values (rst=1 at an edge, from any state):
  - state=IDLE, pc=RESET_VECTOR, instret=0, timeout counter=0.
  - Outputs: fetch_req=0, instr_valid=0, halted=0, fault=0.
  - rst overrides every other input.
- IDLE:
  - pc_src=BREAK.
  - run=1 → FETCH. run is ignored in all other states.
- FETCH:
  - fetch_req=1, pc_src=BREAK; the counter increments each cycle.
  - fetch_ack=1 → EXEC and the counter clears.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack → FAULT, pc unchanged.
  - Ack in the terminal cycle wins over the timeout.
  - Latency is at least 1 cycle in FETCH plus 1 cycle in EXEC per instruction.
- EXEC (exactly one cycle, instr_valid=1):
  - pc_src is combinational with priority ebreak > jalr > jal > (branch & branch_taken) > default.
  - ebreak → BREAK. jalr → ALU. jal or taken branch → TARGET. Otherwise → PLUS4.
  - If ebreak: pc holds, instret holds, next state HALT.
  - Else if pc_next[1:0] != 0: FAULT, pc holds, instret holds.
  - Else: pc <= pc_next, instret <= instret+1 (wraps 2^32-1 → 0), next state FETCH.
- HALT:
  - halted=1, pc_src=BREAK, pc stays at the EBREAK address.
  - resume=1 → pc <= pc_plus4, instret+1, next state FETCH, so the EBREAK is stepped over.
- FAULT:
  - fault=1, pc_src=BREAK, fetch_req=0.
  - Sticky until rst.
- Outputs:
  - halted and fault are registered state decodes.
  - fetch_req, instr_valid and pc_src are decoded from the current state (pc_src also from decode inputs).
- Decode inputs are don't-care outside EXEC and must not affect state.
- pc_plus4 of 32'hFFFF_FFFC wraps to 0. This is not a fault.

Test Plan:
- Reset, run=1, ack one cycle after each request, 4 plain instructions → pc sequence 0,4,8,C,10; instret=4; pc_src=00 in each EXEC.
- At pc=8: branch=1, taken=1, mux returns 0x40 → pc_src=01, pc=0x40. Repeat with taken=0 → pc_src=00, pc=0xC.
- jalr=1 and jal=1 together, pc_next=0x100 → pc_src=10, pc=0x100. Same case with pc_next=0x102 → FAULT, pc unchanged, instret unchanged, fault remains 1 until rst.
- ebreak at pc=0x20 → pc_src=11, halted=1, pc holds 0x20 for 10 cycles. Then resume → pc=0x24, FETCH, instret incremented.
- No ack for 15 cycles → FAULT at 15th FETCH cycle. Ack exactly in cycle 15 → EXEC, no fault.
- rst asserted mid-FETCH and mid-HALT → next cycle IDLE, pc=RESET_VECTOR, instret=0, all flags 0. instret preloaded near max via 2^32 retirements (or force) wraps to 0.
